// File: rtl/udma_adc_seq_pkg.sv
// Shared types and constants for the uDMA ADC channel scan sequencer.
package udma_adc_seq_pkg;

  localparam int unsigned SETTLE_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SETTLE,
    START,
    CONV
  } adc_seq_state_e;

endpackage

// File: rtl/udma_adc_seq_next_ch.sv
// Finds the lowest set mask bit above the current channel index.
// With first=1 the current index is ignored (behaves as index -1).
module udma_adc_seq_next_ch #(
  parameter int unsigned ADC_NUM_CHS = 8,
  parameter int unsigned CH_ID_WIDTH = 4
) (
  input  logic [ADC_NUM_CHS-1:0] mask,
  input  logic [CH_ID_WIDTH-1:0] cur_ch,
  input  logic                   first,
  output logic [CH_ID_WIDTH-1:0] next_ch,
  output logic                   found
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    next_ch = '0;
    found   = 1'b0;
    // Walking downwards lets the lowest qualifying bit be the last one written.
    for (int i = ADC_NUM_CHS - 1; i >= 0; i--) begin
      if (mask[i] && (first || i > int'(cur_ch))) begin
        next_ch = CH_ID_WIDTH'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udma_adc_seq_ctrl.sv
// Channel scan sequencer: settle, start and completion handshake per enabled channel.
// Define UDMA_ADC_SEQ_TIMEOUT_EN to abandon a conversion after TIMEOUT_CYCLES without adc_done_i.
module udma_adc_seq_ctrl
  import udma_adc_seq_pkg::*;
#(
  parameter int unsigned ADC_NUM_CHS    = 8,
  parameter int unsigned CH_ID_WIDTH    = 4,
  parameter int unsigned PERIOD_WIDTH   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    sys_clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_en_i,
  input  logic                    cfg_continuous_i,
  input  logic [ADC_NUM_CHS-1:0]  cfg_ch_mask_i,
  input  logic [PERIOD_WIDTH-1:0] cfg_period_i,
  input  logic [SETTLE_WIDTH-1:0] cfg_settle_i,
  input  logic                    adc_done_i,
  output logic [CH_ID_WIDTH-1:0]  adc_ch_sel_o,
  output logic                    adc_start_o,
  output logic                    busy_o,
  output logic                    scan_done_o,
  output logic                    overrun_o,
  output logic                    timeout_o
);

  if (ADC_NUM_CHS > (1 << CH_ID_WIDTH) || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("udma_adc_seq_ctrl: ADC_NUM_CHS exceeds CH_ID_WIDTH range or TIMEOUT_CYCLES is 0");
  end

  adc_seq_state_e          state_q;
  logic [ADC_NUM_CHS-1:0]  mask_q;
  logic [SETTLE_WIDTH-1:0] settle_cnt_q;
  logic [PERIOD_WIDTH-1:0] period_cnt_q;
  logic                    en_q;
  logic                    abort_q;

  logic                    idle_or_wait;
  logic [ADC_NUM_CHS-1:0]  finder_mask;
  logic [CH_ID_WIDTH-1:0]  next_ch;
  logic                    next_found;
  logic [PERIOD_WIDTH-1:0] period_reload;
  logic                    tick;
  logic                    scan_req;
  logic                    timeout_hit;
  logic                    conv_end;

  assign idle_or_wait  = (state_q == IDLE) || (state_q == WAIT);
  assign busy_o        = !idle_or_wait;
  // A new scan picks from the live mask; an advance walks the latched one.
  assign finder_mask   = idle_or_wait ? cfg_ch_mask_i : mask_q;
  assign period_reload = (cfg_period_i == '0) ? '0 : cfg_period_i - PERIOD_WIDTH'(1);
  assign tick          = (period_cnt_q == '0);

  udma_adc_seq_next_ch #(
    .ADC_NUM_CHS (ADC_NUM_CHS),
    .CH_ID_WIDTH (CH_ID_WIDTH)
  ) u_next_ch (
    .mask    (finder_mask),
    .cur_ch  (adc_ch_sel_o),
    .first   (idle_or_wait),
    .next_ch (next_ch),
    .found   (next_found)
  );

  always_comb begin
    scan_req = 1'b0;
    unique case (state_q)
      IDLE:    scan_req = cfg_continuous_i ? cfg_en_i : (cfg_en_i && !en_q);
      WAIT:    scan_req = cfg_en_i && (tick || cfg_period_i == '0);
      default: scan_req = 1'b0;
    endcase
  end

`ifdef UDMA_ADC_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // A done arriving in the timeout cycle wins, so no timeout is reported then.
  assign timeout_hit = (state_q == CONV) && !adc_done_i &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk_i) begin
    if (!rst_ni) begin
      to_cnt_q  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= timeout_hit;
      to_cnt_q  <= (state_q == CONV) ? to_cnt_q + TO_W'(1) : '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  assign conv_end = (state_q == CONV) && (adc_done_i || timeout_hit);

  always_ff @(posedge sys_clk_i) begin
    // NOTE: all sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    if (!rst_ni) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      settle_cnt_q <= '0;
      period_cnt_q <= '0;
      en_q         <= 1'b0;
      abort_q      <= 1'b0;
      adc_ch_sel_o <= '0;
      adc_start_o  <= 1'b0;
      scan_done_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      en_q        <= cfg_en_i;
      adc_start_o <= 1'b0;
      scan_done_o <= 1'b0;
      overrun_o   <= 1'b0;

      // Period ticks outside WAIT are discarded and the period restarts.
      if (scan_req) begin
        period_cnt_q <= period_reload;
      end else if (state_q != IDLE) begin
        if (tick && !idle_or_wait && cfg_period_i != '0) begin
          overrun_o    <= 1'b1;
          period_cnt_q <= period_reload;
        end else if (!tick) begin
          period_cnt_q <= period_cnt_q - PERIOD_WIDTH'(1);
        end
      end

      unique case (state_q)
        IDLE, WAIT: begin
          abort_q <= 1'b0;
          if (state_q == WAIT && !cfg_en_i) begin
            state_q <= IDLE;
          end else if (scan_req) begin
            mask_q <= cfg_ch_mask_i;
            if (next_found) begin
              adc_ch_sel_o <= next_ch;
              settle_cnt_q <= cfg_settle_i;
              state_q      <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (!cfg_en_i) begin
            state_q <= IDLE;
          end else if (settle_cnt_q == '0) begin
            adc_start_o <= 1'b1;
            state_q     <= START;
          end else begin
            settle_cnt_q <= settle_cnt_q - SETTLE_WIDTH'(1);
          end
        end
        START: begin
          if (!cfg_en_i) abort_q <= 1'b1;
          state_q <= CONV;
        end
        CONV: begin
          if (!cfg_en_i) abort_q <= 1'b1;
          if (conv_end) begin
            if (abort_q || !cfg_en_i) begin
              state_q <= IDLE;
            end else if (next_found) begin
              adc_ch_sel_o <= next_ch;
              settle_cnt_q <= cfg_settle_i;
              state_q      <= SETTLE;
            end else begin
              scan_done_o <= 1'b1;
              state_q     <= cfg_continuous_i ? WAIT : IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_adc_seq_ctrl.sv
// Self-checking bench for udma_adc_seq_ctrl; scan timing is predicted by an event-level model.
module tb_udma_adc_seq_ctrl;

  logic        sys_clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_en_i;
  logic        cfg_continuous_i;
  logic [7:0]  cfg_ch_mask_i;
  logic [15:0] cfg_period_i;
  logic [7:0]  cfg_settle_i;
  logic        adc_done_i;
  logic [3:0]  adc_ch_sel_o;
  logic        adc_start_o;
  logic        busy_o;
  logic        scan_done_o;
  logic        overrun_o;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_dly = 0;
  int pend_q[$];
  int log_st_cyc[$], log_st_ch[$], log_done[$], log_ovr[$], log_tmo[$];

  udma_adc_seq_ctrl #(
    .ADC_NUM_CHS    (8),
    .CH_ID_WIDTH    (4),
    .PERIOD_WIDTH   (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .sys_clk_i        (sys_clk_i),
    .rst_ni           (rst_ni),
    .cfg_en_i         (cfg_en_i),
    .cfg_continuous_i (cfg_continuous_i),
    .cfg_ch_mask_i    (cfg_ch_mask_i),
    .cfg_period_i     (cfg_period_i),
    .cfg_settle_i     (cfg_settle_i),
    .adc_done_i       (adc_done_i),
    .adc_ch_sel_o     (adc_ch_sel_o),
    .adc_start_o      (adc_start_o),
    .busy_o           (busy_o),
    .scan_done_o      (scan_done_o),
    .overrun_o        (overrun_o),
    .timeout_o        (timeout_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;
  always @(posedge sys_clk_i) cyc <= cyc + 1;

  // Event log, sampled mid-cycle.
  always @(negedge sys_clk_i) begin
    if (adc_start_o) begin
      log_st_cyc.push_back(cyc);
      log_st_ch.push_back(int'(adc_ch_sel_o));
      if (done_dly > 0) pend_q.push_back(cyc + done_dly);
    end
    if (scan_done_o) log_done.push_back(cyc);
    if (overrun_o)   log_ovr.push_back(cyc);
    if (timeout_o)   log_tmo.push_back(cyc);
  end

  // ADC model: one-cycle done pulse done_dly cycles after each start.
  initial begin
    adc_done_i = 1'b0;
    forever begin
      @(posedge sys_clk_i);
      #1;
      adc_done_i = 1'b0;
      while (pend_q.size() > 0 && pend_q[0] < cyc) void'(pend_q.pop_front());
      if (pend_q.size() > 0 && pend_q[0] == cyc) begin
        adc_done_i = 1'b1;
        void'(pend_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk_i);
    #1;
  endtask

  task automatic clear_logs();
    log_st_cyc.delete(); log_st_ch.delete(); log_done.delete();
    log_ovr.delete();    log_tmo.delete();   pend_q.delete();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; cfg_en_i = 1'b0; cfg_continuous_i = 1'b0;
    cfg_ch_mask_i = 8'h00; cfg_period_i = 16'd0; cfg_settle_i = 8'd0;
    tick(3);
    checks++;
    if ({adc_ch_sel_o, adc_start_o, busy_o, scan_done_o, overrun_o, timeout_o} !== 9'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {adc_ch_sel_o, adc_start_o, busy_o, scan_done_o, overrun_o, timeout_o});
    end
    rst_ni = 1'b1;
    tick(3);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %0b expected 0", busy_o);
    end
  endtask

  task automatic test_continuous(input string name, input logic [7:0] mask, input int settle,
                                 input int dly, input int period, input int window);
    int n0, cutoff, n, t, k, lim;
    int e_sc[$], e_sh[$], e_dn[$], e_ov[$];
    int g_sc[$], g_sh[$], g_dn[$], g_ov[$];
    cfg_continuous_i = 1'b1; cfg_ch_mask_i = mask;
    cfg_period_i = 16'(period); cfg_settle_i = 8'(settle); done_dly = dly;
    clear_logs();
    tick(1);
    n0 = cyc; cfg_en_i = 1'b1;
    tick(window);
    cutoff = cyc; cfg_en_i = 1'b0;
    tick(settle + dly + 10);

    // Reference: each channel costs settle+2 cycles up to its start plus dly to done;
    // periodic scans begin on the first period boundary after the previous scan ends.
    n = n0;
    while (n <= cutoff) begin
      t = n;
      for (int ch = 0; ch < 8; ch++) begin
        if (mask[ch]) begin
          t = t + 2 + settle;
          if (t <= cutoff) begin e_sc.push_back(t); e_sh.push_back(ch); end
          t = t + dly;
        end
      end
      if (t + 1 <= cutoff) e_dn.push_back(t + 1);
      if (period == 0) begin
        n = t + 1;
      end else begin
        k = n + period;
        while (k <= t) begin
          if (k + 1 <= cutoff) e_ov.push_back(k + 1);
          k = k + period;
        end
        n = k;
      end
    end

    foreach (log_st_cyc[i]) if (log_st_cyc[i] <= cutoff) begin
      g_sc.push_back(log_st_cyc[i]); g_sh.push_back(log_st_ch[i]);
    end
    foreach (log_done[i]) if (log_done[i] <= cutoff) g_dn.push_back(log_done[i]);
    foreach (log_ovr[i])  if (log_ovr[i]  <= cutoff) g_ov.push_back(log_ovr[i]);

    checks++;
    if (g_sc.size() != e_sc.size()) begin
      errors++;
      $display("FAIL %s start_count: got %0d expected %0d", name, g_sc.size(), e_sc.size());
    end
    lim = (g_sc.size() < e_sc.size()) ? g_sc.size() : e_sc.size();
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (g_sc[i] !== e_sc[i] || g_sh[i] !== e_sh[i]) begin
        errors++;
        $display("FAIL %s start[%0d]: got cyc %0d ch %0d expected cyc %0d ch %0d",
                 name, i, g_sc[i] - n0, g_sh[i], e_sc[i] - n0, e_sh[i]);
      end
    end
    checks++;
    if (g_dn.size() != e_dn.size()) begin
      errors++;
      $display("FAIL %s scan_done_count: got %0d expected %0d", name, g_dn.size(), e_dn.size());
    end
    lim = (g_dn.size() < e_dn.size()) ? g_dn.size() : e_dn.size();
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (g_dn[i] !== e_dn[i]) begin
        errors++;
        $display("FAIL %s scan_done[%0d]: got %0d expected %0d", name, i, g_dn[i] - n0, e_dn[i] - n0);
      end
    end
    checks++;
    if (g_ov.size() != e_ov.size()) begin
      errors++;
      $display("FAIL %s overrun_count: got %0d expected %0d", name, g_ov.size(), e_ov.size());
    end
    lim = (g_ov.size() < e_ov.size()) ? g_ov.size() : e_ov.size();
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (g_ov[i] !== e_ov[i]) begin
        errors++;
        $display("FAIL %s overrun[%0d]: got %0d expected %0d", name, i, g_ov[i] - n0, e_ov[i] - n0);
      end
    end
    // Without overruns, first starts of consecutive scans sit exactly one period apart.
    if (period > 0 && e_ov.size() == 0 && g_sc.size() > $countones(mask)) begin
      checks++;
      if (g_sc[$countones(mask)] - g_sc[0] !== period) begin
        errors++;
        $display("FAIL %s scan_spacing: got %0d expected %0d",
                 name, g_sc[$countones(mask)] - g_sc[0], period);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after_disable: got busy %0b expected 0", name, busy_o);
    end
  endtask

  task automatic test_single_shot();
    int n0, s;
    s = $urandom_range(0, 4);
    cfg_continuous_i = 1'b0; cfg_ch_mask_i = 8'h80; cfg_period_i = 16'd0;
    cfg_settle_i = 8'(s); done_dly = 4;
    for (int pass = 0; pass < 2; pass++) begin
      clear_logs();
      tick(1);
      n0 = cyc; cfg_en_i = 1'b1;
      tick(pass == 0 ? 500 : 50);
      checks++;
      if (busy_o !== 1'b0) begin
        errors++;
        $display("FAIL single_idle[%0d]: got busy %0b expected 0", pass, busy_o);
      end
      cfg_en_i = 1'b0;
      tick(5);
      checks++;
      if (log_st_cyc.size() != 1) begin
        errors++;
        $display("FAIL single_start_count[%0d]: got %0d expected 1", pass, log_st_cyc.size());
      end else begin
        checks++;
        if (log_st_cyc[0] - n0 !== 2 + s || log_st_ch[0] !== 7) begin
          errors++;
          $display("FAIL single_start[%0d]: got cyc %0d ch %0d expected cyc %0d ch 7",
                   pass, log_st_cyc[0] - n0, log_st_ch[0], 2 + s);
        end
      end
      checks++;
      if (log_done.size() != 1) begin
        errors++;
        $display("FAIL single_done_count[%0d]: got %0d expected 1", pass, log_done.size());
      end else begin
        checks++;
        if (log_done[0] - n0 !== 2 + s + 4 + 1) begin
          errors++;
          $display("FAIL single_done[%0d]: got %0d expected %0d", pass, log_done[0] - n0, 7 + s);
        end
      end
    end
  endtask

  task automatic test_abort();
    int n0, s1;
    cfg_continuous_i = 1'b1; cfg_ch_mask_i = 8'h03; cfg_period_i = 16'd0;
    cfg_settle_i = 8'd1; done_dly = 6;
    clear_logs();
    tick(1);
    n0 = cyc; cfg_en_i = 1'b1;
    s1 = n0 + 12;
    tick(s1 + 2 - n0);
    cfg_en_i = 1'b0;
    tick(3);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_conv_held: got busy %0b expected 1", busy_o);
    end
    tick(2);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy %0b expected 0", busy_o);
    end
    tick(50);
    checks++;
    if (log_st_cyc.size() != 2) begin
      errors++;
      $display("FAIL abort_start_count: got %0d expected 2", log_st_cyc.size());
    end else begin
      checks++;
      if (log_st_ch[0] !== 0 || log_st_ch[1] !== 1 || log_st_cyc[1] !== s1) begin
        errors++;
        $display("FAIL abort_starts: got ch %0d,%0d cyc1 %0d expected ch 0,1 cyc1 %0d",
                 log_st_ch[0], log_st_ch[1], log_st_cyc[1] - n0, s1 - n0);
      end
    end
    checks++;
    if (log_done.size() != 0) begin
      errors++;
      $display("FAIL abort_scan_done: got %0d expected 0", log_done.size());
    end
  endtask

  task automatic test_timeout();
    int n0, s0;
    cfg_continuous_i = 1'b0; cfg_ch_mask_i = 8'h03; cfg_period_i = 16'd0;
    cfg_settle_i = 8'd2; done_dly = 0;
    clear_logs();
    tick(1);
    n0 = cyc; cfg_en_i = 1'b1;
    s0 = n0 + 4;
`ifdef UDMA_ADC_SEQ_TIMEOUT_EN
    tick(49);
    cfg_en_i = 1'b0;
    checks++;
    if (log_tmo.size() != 2) begin
      errors++;
      $display("FAIL timeout_count: got %0d expected 2", log_tmo.size());
    end else begin
      checks++;
      if (log_tmo[0] !== s0 + 17 || log_tmo[1] !== s0 + 37) begin
        errors++;
        $display("FAIL timeout_cycles: got %0d,%0d expected %0d,%0d",
                 log_tmo[0] - n0, log_tmo[1] - n0, s0 + 17 - n0, s0 + 37 - n0);
      end
    end
    checks++;
    if (log_st_cyc.size() != 2) begin
      errors++;
      $display("FAIL timeout_start_count: got %0d expected 2", log_st_cyc.size());
    end else begin
      checks++;
      if (log_st_cyc[1] !== s0 + 20 || log_st_ch[1] !== 1) begin
        errors++;
        $display("FAIL timeout_advance: got cyc %0d ch %0d expected cyc %0d ch 1",
                 log_st_cyc[1] - n0, log_st_ch[1], s0 + 20 - n0);
      end
    end
    checks++;
    if (log_done.size() != 1 || (log_done.size() == 1 && log_done[0] !== s0 + 37)) begin
      errors++;
      $display("FAIL timeout_scan_done: got count %0d expected 1 at %0d",
               log_done.size(), s0 + 37 - n0);
    end
`else
    tick(120);
    checks++;
    if (busy_o !== 1'b1 || log_st_cyc.size() != 1 || log_tmo.size() != 0 || log_done.size() != 0) begin
      errors++;
      $display("FAIL no_timeout_hold: got busy %0b starts %0d timeouts %0d dones %0d expected 1 1 0 0",
               busy_o, log_st_cyc.size(), log_tmo.size(), log_done.size());
    end
    rst_ni = 1'b0;
    cfg_en_i = 1'b0;
    tick(1);
    rst_ni = 1'b1;
`endif
    tick(3);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_final_idle: got busy %0b expected 0", busy_o);
    end
  endtask

  task automatic test_reset_mid_settle();
    cfg_continuous_i = 1'b1; cfg_ch_mask_i = 8'h10; cfg_period_i = 16'd0;
    cfg_settle_i = 8'd30; done_dly = 3;
    clear_logs();
    tick(1);
    cfg_en_i = 1'b1;
    tick(5);
    checks++;
    if (busy_o !== 1'b1 || adc_ch_sel_o !== 4'd4) begin
      errors++;
      $display("FAIL settle_state: got busy %0b ch %0d expected busy 1 ch 4", busy_o, adc_ch_sel_o);
    end
    rst_ni = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    cfg_en_i = 1'b0;
    checks++;
    if ({adc_ch_sel_o, adc_start_o, busy_o, scan_done_o, overrun_o, timeout_o} !== 9'h0) begin
      errors++;
      $display("FAIL mid_settle_reset: got %h expected 0",
               {adc_ch_sel_o, adc_start_o, busy_o, scan_done_o, overrun_o, timeout_o});
    end
    tick(40);
    checks++;
    if (log_st_cyc.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: got starts %0d busy %0b expected 0 0",
               log_st_cyc.size(), busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_continuous("cont_spec", 8'b0010_0101, 2, 5, 100, 260);
    test_continuous("overrun", 8'h01, 2, 20, 10, 120);
    test_continuous("back_to_back", 8'h81, 1, 3, 0, 80);
    for (int r = 0; r < 4; r++) begin
      test_continuous($sformatf("rand%0d", r), 8'($urandom_range(1, 255)),
                      $urandom_range(0, 5), $urandom_range(1, 8),
                      ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(15, 60), 200);
    end
    test_single_shot();
    test_abort();
    test_timeout();
    test_reset_mid_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
